dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester scheduler for the single-ported data memory (`MEMORY`). It shares the memory between the pipeline memory stage (port M, driven from the MEM_ADDR/MEM_DATA/MEM_READ/MEM_WRITE decode) and a loader/debug port (port L) used to preload and inspect data memory. Port M has priority. Port L is granted on idle M cycles, or forcibly after a bounded starvation window, in which case the memory stage is stalled.

## Interface
Parameters:
- `DW`, 32: data width, and the width of both port addresses.
- `STARVE`, 4: number of consecutive cycles with L pending and M busy after which L is forced in. Legal range 1..15.

Ports:
- `CLK`  in  1: clock. All state updates on the rising edge.
- `RST_N`  in  1: reset. Asynchronous, active-low.
- `m_read`  in  1: memory stage read request this cycle.
- `m_write`  in  1: memory stage write request this cycle.
- `m_addr`  in  DW: memory stage address.
- `m_wdata`  in  DW: memory stage write data.
- `m_rdata`  out  DW: read data to the memory stage (valM path).
- `m_error`  out  1: dmem_error for an M access, feeds STAT.
- `m_stall`  out  1: memory stage access not serviced this cycle; hold the instruction.
- `l_req`  in  1: loader request. Level; hold until `l_done`.
- `l_we`  in  1: 1 = write, 0 = read.
- `l_addr`  in  DW: loader address.
- `l_wdata`  in  DW: loader write data.
- `l_gnt`  out  1: loader owns memory this cycle.
- `l_rdata`  out  DW: registered loader read data.
- `l_err`  out  1: registered dmem_error of the loader access.
- `l_done`  out  1: one-cycle pulse; loader transaction complete.
- `mem_addr`, `mem_wdata`  out  DW: to `MEMORY` addr / write_data.
- `mem_write`, `mem_read`  out  1: to `MEMORY` write_flag / read_flag.
- `mem_rdata`  in  DW: from `MEMORY` valM.
- `mem_error`  in  1: from `MEMORY` dmem_error.

## Operation
- `m_act` = `m_read | m_write`.
- States:
  - `M_OWN`: reset and default state.
  - `L_OWN`: lasts exactly one cycle.
- `M_OWN` behaviour:
  - The mem_* outputs mirror port M combinationally.
  - `m_rdata` = `mem_rdata`, `m_error` = `mem_error`.
  - `l_gnt` = 0, `m_stall` = 0.
- `L_OWN` behaviour:
  - `mem_addr` = `l_addr`, `mem_wdata` = `l_wdata`.
  - `mem_write` = `l_we`, `mem_read` = `~l_we`.
  - `l_gnt` = 1.
  - `m_stall` = `m_act`. M's write is suppressed, `m_rdata` = 0, `m_error` = 0.
- Transition `M_OWN` -> `L_OWN` when `l_req & (~m_act | starve_cnt == STARVE-1)`.
- Transition `L_OWN` -> `M_OWN` always. Grants are never back-to-back, so M gets at least every other cycle.
- `starve_cnt` (4 bits):
  - Increments in `M_OWN` when `l_req & m_act`.
  - Clears on entering `L_OWN`, or in any cycle with `l_req` = 0.
  - Never exceeds `STARVE-1`.
- On the `L_OWN` edge, register `l_rdata` <= `mem_rdata` (read only; unchanged on write) and `l_err` <= `mem_error`. `l_done` is 1 in the following cycle only.
- Withdrawal: if `l_req` drops before grant, nothing happens and the counter clears. After `l_done`, a still-high `l_req` is a new transaction.
- Address range checking is owned by `MEMORY`. The arbiter only routes `mem_error`.

## Timing
- Reset values: state `M_OWN`, `starve_cnt` = 0, `l_rdata` = 0, `l_err` = 0, `l_done` = 0, `l_gnt` = 0.
  - `m_stall` = 0 during reset.
  - The mem_* outputs follow port M during reset.
- Loader latency, best case: `l_req` rises in cycle t with M idle, `l_gnt` in t+1, `l_done` in t+2.
- Loader latency, worst case with M continuously busy: `l_gnt` in t+STARVE, `l_done` in t+STARVE+1.
- M read is combinational through `MEMORY`, with zero added latency in `M_OWN`.
- Stall: exactly one cycle per forced grant.
- Reset asserted mid-`L_OWN`:
  - State returns to `M_OWN` immediately.
  - `mem_write` follows M, so the loader write is not committed unless a clock edge occurred before reset.
  - `l_done` is not pulsed.
- Simultaneous `l_req` rise and `m_act` with `STARVE` = 1: L is granted next cycle.

## Test plan
- **Reset:** assert `RST_N` = 0 mid-run. All registered outputs are 0, state is `M_OWN`, and `m_write` = 1 passes through to `mem_write`.
- **Idle grant:** M idle, L write 0x07 <- 0x77; then L read 0x07. `l_gnt` for one cycle each, and `l_rdata` = 0x77 with `l_done` in the cycle after the read grant.
- **Priority:** M writes 0x11 to 0x01 every cycle, L reads 0x01, `STARVE` = 4. `l_gnt` exactly 4 cycles after `l_req`, `m_stall` = 1 that cycle only, and `l_rdata` = 0x11.
- **Stall integrity:** during a forced grant, M write 0x22 -> 0x02 is presented and stalled, then replayed next cycle. A following M read of 0x02 returns 0x22, with no write in the stall cycle.
- **Error routing:** L read of an out-of-range address. `l_err` = 1 with `l_done`, and `m_error` stays 0.
- **Withdrawal and mid-grant reset:** `l_req` dropped after 2 busy cycles gives no grant and the counter clears. Reset during `L_OWN` gives no `l_done`, and target 0x05 keeps its old value 0x55.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: memory-stage port, loader port and MEMORY-side signals of the data-memory arbiter.
`default_nettype none

interface dmem_arbiter_if #(
    parameter int DW = 32
);
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_error;
    logic          m_stall;

    logic          l_req;
    logic          l_we;
    logic [DW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic [DW-1:0] l_rdata;
    logic          l_err;
    logic          l_done;

    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rdata;
    logic          mem_error;

    // Arbiter side
    modport slave (
        input  m_read, m_write, m_addr, m_wdata,
        output m_rdata, m_error, m_stall,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rdata, l_err, l_done,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata, mem_error
    );

    // Environment side: requesters plus the memory
    modport master (
        output m_read, m_write, m_addr, m_wdata,
        input  m_rdata, m_error, m_stall,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rdata, l_err, l_done,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata, mem_error
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-ported data memory between the memory stage (priority)
// and a loader port that is forced in after STARVE busy cycles.
`default_nettype none

module dmem_arbiter #(
    parameter int DW     = 32,
    parameter int STARVE = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LAST = 4'(STARVE - 1);

    typedef enum logic [0:0] {
        M_OWN = 1'b0,
        L_OWN = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       m_act;

    assign m_act = bus.m_read | bus.m_write;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= M_OWN;
            starve_cnt  <= 4'd0;
            bus.l_gnt   <= 1'b0;
            bus.l_done  <= 1'b0;
            bus.l_err   <= 1'b0;
            bus.l_rdata <= '0;
        end else begin
            case (state)
                M_OWN: begin
                    bus.l_done <= 1'b0;
                    if (!bus.l_req) begin
                        starve_cnt <= 4'd0;
                    end else if (!m_act || starve_cnt == STARVE_LAST) begin
                        state      <= L_OWN;
                        starve_cnt <= 4'd0;
                        bus.l_gnt  <= 1'b1;
                    end else begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                L_OWN: begin
                    // Single-cycle grant; M always gets the following cycle.
                    state      <= M_OWN;
                    starve_cnt <= 4'd0;
                    bus.l_gnt  <= 1'b0;
                    bus.l_done <= 1'b1;
                    bus.l_err  <= bus.mem_error;
                    if (!bus.l_we) begin
                        bus.l_rdata <= bus.mem_rdata;
                    end
                end
                default: begin
                    state      <= M_OWN;
                    starve_cnt <= 4'd0;
                    bus.l_gnt  <= 1'b0;
                    bus.l_done <= 1'b0;
                end
            endcase
        end
    end

    // Memory routing: M passes straight through except during a loader grant.
    always_comb begin
        bus.mem_addr  = bus.m_addr;
        bus.mem_wdata = bus.m_wdata;
        bus.mem_write = bus.m_write;
        bus.mem_read  = bus.m_read;
        bus.m_rdata   = bus.mem_rdata;
        bus.m_error   = bus.mem_error;
        bus.m_stall   = 1'b0;
        if (state == L_OWN) begin
            bus.mem_addr  = bus.l_addr;
            bus.mem_wdata = bus.l_wdata;
            bus.mem_write = bus.l_we;
            bus.mem_read  = ~bus.l_we;
            bus.m_rdata   = {DW{1'b0}};
            bus.m_error   = 1'b0;
            bus.m_stall   = m_act;
        end
    end

endmodule

`default_nettype wire
